// File: rtl/pilha_lifo_pkg.sv
// Processor-wide stack definitions: command encodings, default geometry and
// the handshake FSM state codes shared by the operand stack and its users.
package pilha_lifo_pkg;

    localparam int STK_DATA_W = 16;
    localparam int STK_DEPTH  = 16;

    localparam logic [1:0] STK_NOP     = 2'b00;
    localparam logic [1:0] STK_PUSH    = 2'b01;
    localparam logic [1:0] STK_POP     = 2'b10;
    localparam logic [1:0] STK_REPLACE = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/pilha_mem.sv
// Stack storage: DEPTH x DATA_W register file, one synchronous write port and
// one asynchronous read port. Kept separate so a RAM macro can replace it.
module pilha_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pilha_lifo.sv
// Hardware operand stack with a req/ack command handshake (IDLE->EXEC->DONE),
// registered pop data, combinational top-of-stack and sticky error flags.
module pilha_lifo
    import pilha_lifo_pkg::*;
#(
    parameter int DATA_W = STK_DATA_W,
    parameter int DEPTH  = STK_DEPTH,
    parameter int PTR_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear_err,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] top,
    output logic [PTR_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic [PTR_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              exec;
    logic              mem_we;
    logic [AW-1:0]     push_idx;
    logic [AW-1:0]     top_idx;
    logic [DATA_W-1:0] rd_data;

    assign empty = (count_q == '0);
    assign full  = (count_q == PTR_W'(DEPTH));
    assign exec  = (state_q == S_EXEC);

    // When count==DEPTH the low bits wrap to 0, so the top index (low bits - 1)
    // still lands on DEPTH-1; the push index is never used in that case.
    assign push_idx = count_q[AW-1:0];
    assign top_idx  = count_q[AW-1:0] - AW'(1);

    assign mem_we = exec && (((op_q == STK_PUSH) && !full) ||
                             ((op_q == STK_REPLACE) && !empty));

    pilha_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk_i   (clock),
        .we_i    (mem_we),
        .waddr_i ((op_q == STK_PUSH) ? push_idx : top_idx),
        .wdata_i (data_q),
        .raddr_i (top_idx),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // clear_err is applied first so a same-cycle error sets the flag anyway.
    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        ovf_d   = clear_err ? 1'b0 : ovf_q;
        udf_d   = clear_err ? 1'b0 : udf_q;
        if (exec) begin
            case (op_q)
                STK_PUSH: begin
                    if (full) ovf_d = 1'b1;
                    else      count_d = count_q + PTR_W'(1);
                end
                STK_POP: begin
                    if (empty) begin
                        dout_d = '0;
                        udf_d  = 1'b1;
                    end else begin
                        dout_d  = rd_data;
                        count_d = count_q - PTR_W'(1);
                    end
                end
                STK_REPLACE: begin
                    if (empty) udf_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= STK_NOP;
            data_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            if ((state_q == S_IDLE) && req) begin
                op_q   <= op;
                data_q <= data_in;
            end
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign ack       = (state_q == S_DONE);
    assign data_out  = dout_q;
    assign top       = empty ? '0 : rd_data;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_pilha_lifo.sv
// Scoreboard bench for pilha_lifo: a behavioural stack model queues the
// expected post-command state, checked when the DUT acks.
module tb_pilha_lifo;

    localparam int DW = 16;
    localparam int DP = 16;
    localparam int PW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [DW-1:0] data_in = '0;
    logic          clear_err = 1'b0;
    logic          ready, ack, empty, full, overflow, underflow;
    logic [DW-1:0] data_out, top;
    logic [PW-1:0] count;

    pilha_lifo #(.DATA_W(DW), .DEPTH(DP), .PTR_W(PW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .data_in   (data_in),
        .clear_err (clear_err),
        .ready     (ready),
        .ack       (ack),
        .data_out  (data_out),
        .top       (top),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] dout;
        logic [DW-1:0] top;
        logic [PW-1:0] cnt;
        logic          ovf;
        logic          udf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [DW-1:0] m_mem [DP];
    int            m_cnt = 0;
    logic [DW-1:0] m_dout = '0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_cmd(input logic [1:0] o, input logic [DW-1:0] d, input bit clr);
        exp_t e;
        if (clr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        case (o)
            2'b01: if (m_cnt == DP) m_ovf = 1'b1;
                   else begin m_mem[m_cnt] = d; m_cnt++; end
            2'b10: if (m_cnt == 0) begin m_dout = '0; m_udf = 1'b1; end
                   else begin m_cnt--; m_dout = m_mem[m_cnt]; end
            2'b11: if (m_cnt == 0) m_udf = 1'b1;
                   else m_mem[m_cnt-1] = d;
            default: ;
        endcase
        e.dout = m_dout;
        e.top  = (m_cnt == 0) ? '0 : m_mem[m_cnt-1];
        e.cnt  = PW'(m_cnt);
        e.ovf  = m_ovf;
        e.udf  = m_udf;
        sb.push_back(e);
    endtask

    task automatic compare_front(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_underrun"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_dout"},  32'(data_out),  32'(e.dout));
        check({tag, "_top"},   32'(top),       32'(e.top));
        check({tag, "_count"}, 32'(count),     32'(e.cnt));
        check({tag, "_ovf"},   32'(overflow),  32'(e.ovf));
        check({tag, "_udf"},   32'(underflow), 32'(e.udf));
        check({tag, "_empty"}, 32'(empty),     32'(e.cnt == 0));
        check({tag, "_full"},  32'(full),      32'(e.cnt == PW'(DP)));
    endtask

    // Called at a negedge while idle; returns at a negedge, idle again.
    task automatic issue(input string tag, input logic [1:0] o, input logic [DW-1:0] d, input bit clr);
        int lat;
        bit got;
        check({tag, "_ready_pre"}, 32'(ready), 32'd1);
        req = 1'b1; op = o; data_in = d;
        model_cmd(o, d, clr);
        @(negedge clock);
        req = 1'b0; clear_err = clr;
        lat = 1; got = 1'b0;
        check({tag, "_ack_early"}, 32'(ack), 32'd0);
        while (!got && lat < 10) begin
            @(negedge clock);
            clear_err = 1'b0;
            lat++;
            if (ack) got = 1'b1;
        end
        if (got) begin
            check({tag, "_latency"}, 32'(lat), 32'd2);
            compare_front(tag);
        end else begin
            check({tag, "_ack_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        @(negedge clock);
        check({tag, "_ack_pulse"}, 32'(ack), 32'd0);
        check({tag, "_ready_post"}, 32'(ready), 32'd1);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    initial begin
        int acks;

        // Reset and idle
        repeat (2) @(negedge clock);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        reset = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clock);
            if (ack) acks++;
        end
        check("idle_no_ack", 32'(acks), 32'd0);
        check("idle_empty", 32'(empty), 32'd1);
        check("idle_full", 32'(full), 32'd0);
        check("idle_top", 32'(top), 32'd0);
        check("idle_dout", 32'(data_out), 32'd0);
        check("idle_flags", {30'd0, overflow, underflow}, 32'd0);

        // Basic push/push/pop
        issue("push5", 2'b01, 16'h0005, 1'b0);
        issue("pushABCD", 2'b01, 16'hABCD, 1'b0);
        issue("popABCD", 2'b10, 16'h0000, 1'b0);
        issue("pop5", 2'b10, 16'h0000, 1'b0);

        // Fill, overflow, clear
        for (int i = 1; i <= DP; i++) issue("fill", 2'b01, 16'(i), 1'b0);
        issue("push_ovf", 2'b01, 16'h00FF, 1'b0);
        issue("pop16", 2'b10, 16'h0000, 1'b0);
        pulse_clear();
        check("clr_ovf", 32'(overflow), 32'(m_ovf));
        for (int i = 0; i < DP - 1; i++) issue("drain", 2'b10, 16'h0000, 1'b0);

        // Underflow
        issue("pop_empty", 2'b10, 16'h0000, 1'b0);
        issue("repl_empty", 2'b11, 16'h1234, 1'b0);
        issue("nop", 2'b00, 16'hFFFF, 1'b0);
        pulse_clear();
        check("clr_udf", 32'(underflow), 32'd0);

        // Replace
        issue("push3", 2'b01, 16'h0003, 1'b0);
        issue("push4", 2'b01, 16'h0004, 1'b0);
        issue("repl7", 2'b11, 16'h0007, 1'b0);
        issue("pop7", 2'b10, 16'h0000, 1'b0);
        issue("pop3", 2'b10, 16'h0000, 1'b0);

        // req held high: one command per IDLE visit
        for (int i = 0; i < 3; i++) model_cmd(2'b01, 16'h0011, 1'b0);
        req = 1'b1; op = 2'b01; data_in = 16'h0011;
        acks = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            if (i == 6) req = 1'b0;
            if (ack) begin
                acks++;
                compare_front("held");
            end
        end
        check("held_acks", 32'(acks), 32'd3);
        check("held_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) issue("held_pop", 2'b10, 16'h0000, 1'b0);

        // New error coincident with clear_err: set wins
        issue("pop_empty_clr", 2'b10, 16'h0000, 1'b1);
        check("set_wins_udf", 32'(underflow), 32'd1);
        pulse_clear();

        // Asynchronous reset during EXEC of a push
        issue("pre_rst_a", 2'b01, 16'h00AA, 1'b0);
        issue("pre_rst_b", 2'b10, 16'h0000, 1'b0);
        issue("pre_rst_c", 2'b01, 16'h00BB, 1'b0);
        req = 1'b1; op = 2'b01; data_in = 16'h00CC;
        @(negedge clock);
        req = 1'b0;
        check("exec_not_ready", 32'(ready), 32'd0);
        reset = 1'b0;
        #1;
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_count", 32'(count), 32'd0);
        check("arst_dout", 32'(data_out), 32'd0);
        check("arst_ack", 32'(ack), 32'd0);
        m_cnt = 0; m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clock);
            if (ack) acks++;
        end
        check("arst_no_ack", 32'(acks), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        issue("post_rst_push", 2'b01, 16'h0042, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pilha_lifo.md
Name: pilha_lifo

Overview:
- Hardware operand stack that services push/pop/replace commands issued by the control unit over a req/ack handshake.
- Holds DEPTH words of DATA_W bits and exposes top-of-stack, occupancy and sticky error flags.
- Sits between the control unit and the ALU temp registers.
- The ALU result write-back uses the replace operation.

Parameters:
- DATA_W, 16: word width; matches the data memory width.
- DEPTH, 16: number of stack entries; must be a power of two, at least 2.
- PTR_W, 5: occupancy counter width; must equal log2(DEPTH)+1.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  command strobe; sampled only while ready=1.
- op  in  2  command: 00 NOP, 01 PUSH, 10 POP, 11 REPLACE (overwrite top).
- data_in  in  DATA_W  write data for PUSH/REPLACE; captured with req.
- clear_err  in  1  synchronous clear of overflow/underflow.
- ready  out  1  high in IDLE; the block accepts a command.
- ack  out  1  one-cycle pulse when a command completes.
- data_out  out  DATA_W  popped word, registered; valid while ack=1 and held until the next POP.
- top  out  DATA_W  current top of stack; 0 when empty.
- count  out  PTR_W  number of valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; set by PUSH when full.
- underflow  out  1  sticky; set by POP or REPLACE when empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; sp/count=0; data_out=0; ack=0; overflow=underflow=0; latched op/data cleared.
  - ready=1, empty=1, full=0, top=0.
  - Storage array is not cleared; its contents are don't-care.
  - Reset mid-command aborts the command: no write, no ack.
- FSM has three states: IDLE -> EXEC -> DONE -> IDLE.
  - IDLE: ready=1. On req=1, latch op and data_in and go to EXEC. req=0 stays in IDLE.
  - EXEC: ready=0. Perform the latched op (below); go to DONE.
  - DONE: ready=0, ack=1 for exactly one cycle; go to IDLE.
  - Latency: req sampled at edge N; state update at edge N+1; ack high during cycle N+2. A back-to-back req is accepted at the earliest at edge N+3.
  - req while ready=0 is ignored: no queueing, no error.
- Operations, all evaluated in EXEC against the pre-op count:
  - PUSH, not full: mem[count] <= data; count+1.
  - PUSH, full: no write, count unchanged, overflow <= 1.
  - POP, not empty: data_out <= mem[count-1]; count-1.
  - POP, empty: data_out <= 0, count unchanged, underflow <= 1.
  - REPLACE, not empty: mem[count-1] <= data; count unchanged.
  - REPLACE, empty: no write, underflow <= 1.
  - NOP: no state change except the ack sequence. NOP still acks.
- top = mem[count-1] when count>0, else 0. It is combinational from registered state and reflects the new value from the cycle after the EXEC edge, coincident with ack.
- Flags:
  - empty and full are decoded combinationally from count.
  - Error flags persist until clear_err or reset.
  - clear_err in the same cycle as a new error: set wins.
- Width rules: count never wraps (saturates by the rules above). The index is count's low log2(DEPTH) bits, except that count==DEPTH only ever indexes via count-1.
- data_out is unchanged by PUSH, REPLACE and NOP.

Decomposition:
- Shared package (processor-wide):
  - Op encodings STK_NOP/STK_PUSH/STK_POP/STK_REPLACE.
  - Default DATA_W=16 and DEPTH=16.
  - FSM state encodings S_IDLE/S_EXEC/S_DONE.
- One sub-module, pilha_mem:
  - DEPTH x DATA_W register file with one synchronous write port and one asynchronous read port.
  - Keeps storage separable for later RAM-macro substitution.
- The FSM, pointer and flags stay in pilha_lifo.

Test Plan:
- Reset then idle -> ready=1, empty=1, count=0, top=0, ack never asserts.
- PUSH 0x0005, PUSH 0xABCD, POP -> acks two cycles after each accepted req; top=0xABCD after the second push; POP gives data_out=0xABCD, count=1, top=0x0005.
- Fill with 16 PUSHes (values 1..16), then a 17th PUSH 0x00FF:
  - full=1, count=16, overflow=1, top=16.
  - POP then returns 16.
  - clear_err alone clears overflow.
- POP on empty -> data_out=0, underflow=1, count=0. REPLACE on empty -> underflow stays 1, empty stays 1.
- PUSH 3, PUSH 4, REPLACE 0x0007 -> count=2, top=7. POP returns 7, then POP returns 3. Also hold req high continuously: exactly one command accepted per IDLE visit.
- Assert reset low during EXEC of a PUSH -> asynchronous clear; no ack; count=0, ready=1 immediately. Separately: error and clear_err in the same cycle -> flag stays 1.
